key_event_ctrl: RTL

Parametrised multi-key front end. It synchronises NUM_KEYS raw push-button inputs into the Clk_50MHz domain and debounces them on a shared sample tick. For each key it emits single-cycle press, release, long-press and auto-repeat events, plus a per-key toggle register. It replaces the per-key debounce/sample-clock pair and the LED-toggle logic with one fully synchronous block feeding the clock-setting UI and LED bank.

---
 rtl/key_event_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// Multi-key front end: synchronises and debounces NUM_KEYS push-buttons on a shared
// sample tick and emits press, release, long-press and auto-repeat strobes plus a per-key toggle.
module key_event_ctrl #(
    parameter int NUM_KEYS       = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int SAMPLE_DIV     = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic                Clk_50MHz,
    input  logic                Reset_N,
    input  logic [NUM_KEYS-1:0] keyin,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic [NUM_KEYS-1:0] toggle,
    output logic                any_press
);

    localparam int DIV_W    = $clog2(SAMPLE_DIV);
    localparam int HOLD_MAX = LONG_TICKS - DEBOUNCE_TICKS;
    localparam int CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int REP_W    = $clog2(REPEAT_TICKS + 1);

    localparam logic [NUM_KEYS-1:0] REL_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DEB_PRESS = 3'd1;
    localparam logic [2:0] S_PRESSED   = 3'd2;
    localparam logic [2:0] S_LONG      = 3'd3;
    localparam logic [2:0] S_DEB_REL   = 3'd4;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] raw_p;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Synchronisers come out of reset at the released level so no phantom press is seen.
    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            sync1 <= REL_LEVEL;
            sync2 <= REL_LEVEL;
        end else begin
            sync1 <= keyin;
            sync2 <= sync1;
        end
    end

    assign raw_p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            logic [2:0]        state;
            logic [CNT_W-1:0]  cnt;
            logic [CNT_W-1:0]  cnt_inc;
            logic [HOLD_W-1:0] hold;
            logic [HOLD_W-1:0] hold_inc;
            logic [REP_W-1:0]  rep;
            logic [REP_W-1:0]  rep_inc;
            logic              was_long;
            logic              level;
            logic              press_q;
            logic              release_q;
            logic              long_q;
            logic              repeat_q;
            logic              toggle_q;

            assign cnt_inc  = cnt + 1'b1;
            assign hold_inc = (hold == HOLD_W'(HOLD_MAX)) ? hold : hold + 1'b1;
            assign rep_inc  = (rep == REP_W'(REPEAT_TICKS)) ? rep : rep + 1'b1;

            // IDLE entry and DEB_REL exit both count from cnt=0, so one increment path
            // covers the single-tick debounce case without special states.
            always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
                if (!Reset_N) begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    hold      <= '0;
                    rep       <= '0;
                    was_long  <= 1'b0;
                    level     <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    long_q    <= 1'b0;
                    repeat_q  <= 1'b0;
                    toggle_q  <= 1'b0;
                end else begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    long_q    <= 1'b0;
                    repeat_q  <= 1'b0;
                    if (tick) begin
                        case (state)
                            S_IDLE, S_DEB_PRESS: begin
                                if (!raw_p[k]) begin
                                    state <= S_IDLE;
                                    cnt   <= '0;
                                end else if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                                    state    <= S_PRESSED;
                                    cnt      <= '0;
                                    hold     <= '0;
                                    rep      <= '0;
                                    was_long <= 1'b0;
                                    level    <= 1'b1;
                                    press_q  <= 1'b1;
                                    toggle_q <= ~toggle_q;
                                end else begin
                                    state <= S_DEB_PRESS;
                                    cnt   <= cnt_inc;
                                end
                            end
                            S_PRESSED, S_LONG, S_DEB_REL: begin
                                if (!raw_p[k]) begin
                                    if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                                        state     <= S_IDLE;
                                        cnt       <= '0;
                                        level     <= 1'b0;
                                        release_q <= 1'b1;
                                    end else begin
                                        state <= S_DEB_REL;
                                        cnt   <= cnt_inc;
                                    end
                                end else if (state == S_DEB_REL) begin
                                    state <= was_long ? S_LONG : S_PRESSED;
                                    cnt   <= '0;
                                end else if (state == S_PRESSED) begin
                                    hold <= hold_inc;
                                    if (hold_inc == HOLD_W'(HOLD_MAX)) begin
                                        state    <= S_LONG;
                                        was_long <= 1'b1;
                                        rep      <= '0;
                                        long_q   <= 1'b1;
                                    end
                                end else begin
                                    if (rep_inc == REP_W'(REPEAT_TICKS)) begin
                                        rep      <= '0;
                                        repeat_q <= 1'b1;
                                    end else begin
                                        rep <= rep_inc;
                                    end
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end
                        endcase
                    end
                end
            end

            assign key_state[k]     = level;
            assign press_pulse[k]   = press_q;
            assign release_pulse[k] = release_q;
            assign long_pulse[k]    = long_q;
            assign repeat_pulse[k]  = repeat_q;
            assign toggle[k]        = toggle_q;
        end
    endgenerate

    assign any_press = |press_pulse;

endmodule
